// File: rtl/script_stack_exec.sv
// Script main stack and operand sequencer feeding the script ALU.
// Pops operands for each opcode, pushes ALU results back, streams pop_req items and reports the verdict.
module script_stack_exec #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 16,
    parameter int SP_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lit_valid,
    input  logic [DATA_W-1:0] lit_data,
    input  logic              op_valid,
    input  logic [7:0]        op_code,
    input  logic [1:0]        op_nargs,
    output logic              in_ready,
    input  logic              eval_end,
    output logic [7:0]        opcode,
    output logic              put_alu_in1,
    output logic [DATA_W-1:0] data_alu_in1,
    output logic              put_alu_in2,
    output logic [DATA_W-1:0] data_alu_in2,
    input  logic              put_alu_out1,
    input  logic [DATA_W-1:0] data_alu_out1,
    input  logic              put_alu_out2,
    input  logic [DATA_W-1:0] data_alu_out2,
    input  logic              pop_req,
    input  logic              done,
    input  logic              error,
    output logic [SP_W-1:0]   sp,
    output logic              result_valid,
    output logic              result_true,
    output logic              stack_err
);
    localparam int AW = SP_W - 1;
    localparam logic [SP_W-1:0] FULL = SP_W'(DEPTH);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PUSH2, ERR} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [1:0]        nargs;
    logic [SP_W-1:0]   nargs_ext;
    logic [SP_W-1:0]   base;
    logic [AW-1:0]     top_idx;
    logic [AW-1:0]     next_idx;
    logic              pop_ok;
    logic              wr_en;
    logic [AW-1:0]     wr_idx;
    logic [DATA_W-1:0] wr_data;

    assign in_ready  = (state == IDLE);
    assign nargs_ext = SP_W'(op_nargs);
    assign top_idx   = AW'(sp - SP_W'(1));
    assign next_idx  = AW'(sp - SP_W'(2));
    assign pop_ok    = pop_req && (sp != '0);
    // A pop serviced in the done cycle frees the top slot, so the result lands there.
    assign base      = pop_ok ? sp - SP_W'(1) : sp;

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = lit_data;
        case (state)
            IDLE: begin
                if (!eval_end && !op_valid && lit_valid && sp != FULL) begin
                    wr_en  = 1'b1;
                    wr_idx = AW'(sp);
                end
            end
            WAIT: begin
                if (!error && !(pop_req && sp == '0) && done && put_alu_out1 && base != FULL) begin
                    wr_en   = 1'b1;
                    wr_idx  = AW'(base);
                    wr_data = data_alu_out1;
                end
            end
            PUSH2: begin
                if (sp != FULL) begin
                    wr_en   = 1'b1;
                    wr_idx  = AW'(sp);
                    wr_data = data_alu_out2;
                end
            end
            default: wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst && wr_en) mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            sp           <= '0;
            opcode       <= 8'h00;
            nargs        <= '0;
            put_alu_in1  <= 1'b0;
            put_alu_in2  <= 1'b0;
            data_alu_in1 <= '0;
            data_alu_in2 <= '0;
            result_valid <= 1'b0;
            result_true  <= 1'b0;
            stack_err    <= 1'b0;
        end else begin
            put_alu_in1  <= 1'b0;
            put_alu_in2  <= 1'b0;
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (eval_end) begin
                        result_valid <= 1'b1;
                        result_true  <= (sp != '0) && (mem[top_idx] != '0);
                    end else if (op_valid) begin
                        if (op_nargs == 2'd3 || nargs_ext > sp) begin
                            stack_err <= 1'b1;
                            state     <= ERR;
                        end else begin
                            opcode <= op_code;
                            nargs  <= op_nargs;
                            if (op_nargs != 2'd0) data_alu_in1 <= mem[top_idx];
                            if (op_nargs == 2'd2) data_alu_in2 <= mem[next_idx];
                            sp    <= sp - nargs_ext;
                            state <= ISSUE;
                        end
                    end else if (lit_valid) begin
                        if (sp == FULL) begin
                            stack_err <= 1'b1;
                            state     <= ERR;
                        end else begin
                            sp <= sp + SP_W'(1);
                        end
                    end
                end
                ISSUE: begin
                    put_alu_in1 <= (nargs != 2'd0);
                    put_alu_in2 <= (nargs == 2'd2);
                    state       <= WAIT;
                end
                WAIT: begin
                    if (error || (pop_req && sp == '0)) begin
                        stack_err <= 1'b1;
                        state     <= ERR;
                    end else begin
                        if (pop_ok) begin
                            data_alu_in1 <= mem[top_idx];
                            put_alu_in1  <= 1'b1;
                            sp           <= sp - SP_W'(1);
                        end
                        if (done) begin
                            if (put_alu_out1 && base == FULL) begin
                                stack_err <= 1'b1;
                                state     <= ERR;
                            end else begin
                                if (put_alu_out1) sp <= base + SP_W'(1);
                                if (put_alu_out2) begin
                                    state <= PUSH2;
                                end else begin
                                    state  <= IDLE;
                                    opcode <= 8'h00;
                                end
                            end
                        end
                    end
                end
                PUSH2: begin
                    if (sp == FULL) begin
                        stack_err <= 1'b1;
                        state     <= ERR;
                    end else begin
                        sp     <= sp + SP_W'(1);
                        opcode <= 8'h00;
                        state  <= IDLE;
                    end
                end
                ERR: stack_err <= 1'b1;
                default: begin
                    stack_err <= 1'b1;
                    state     <= ERR;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_script_stack_exec.sv
// Bench for script_stack_exec: table-driven two-operand flows plus hand-written corner sequences,
// with ALU operand and verdict pulses checked against queued expectations.
module tb_script_stack_exec;
    localparam int DATA_W = 512;
    localparam int DEPTH  = 16;
    localparam int SP_W   = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              lit_valid;
    logic [DATA_W-1:0] lit_data;
    logic              op_valid;
    logic [7:0]        op_code;
    logic [1:0]        op_nargs;
    logic              in_ready;
    logic              eval_end;
    logic [7:0]        opcode;
    logic              put_alu_in1;
    logic [DATA_W-1:0] data_alu_in1;
    logic              put_alu_in2;
    logic [DATA_W-1:0] data_alu_in2;
    logic              put_alu_out1;
    logic [DATA_W-1:0] data_alu_out1;
    logic              put_alu_out2;
    logic [DATA_W-1:0] data_alu_out2;
    logic              pop_req;
    logic              done;
    logic              error;
    logic [SP_W-1:0]   sp;
    logic              result_valid;
    logic              result_true;
    logic              stack_err;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] q_in1 [$];
    logic [DATA_W-1:0] q_in2 [$];
    logic              q_res [$];

    script_stack_exec #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SP_W(SP_W)) dut (
        .clk(clk), .rst(rst),
        .lit_valid(lit_valid), .lit_data(lit_data),
        .op_valid(op_valid), .op_code(op_code), .op_nargs(op_nargs),
        .in_ready(in_ready), .eval_end(eval_end), .opcode(opcode),
        .put_alu_in1(put_alu_in1), .data_alu_in1(data_alu_in1),
        .put_alu_in2(put_alu_in2), .data_alu_in2(data_alu_in2),
        .put_alu_out1(put_alu_out1), .data_alu_out1(data_alu_out1),
        .put_alu_out2(put_alu_out2), .data_alu_out2(data_alu_out2),
        .pop_req(pop_req), .done(done), .error(error), .sp(sp),
        .result_valid(result_valid), .result_true(result_true), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got pulse expected none", name);
    endtask

    // Scoreboard side: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (put_alu_in1 === 1'b1) begin
            if (q_in1.size() == 0) unexpected("alu_in1_pulse");
            else check("alu_in1", data_alu_in1, q_in1.pop_front());
        end
        if (put_alu_in2 === 1'b1) begin
            if (q_in2.size() == 0) unexpected("alu_in2_pulse");
            else check("alu_in2", data_alu_in2, q_in2.pop_front());
        end
        if (result_valid === 1'b1) begin
            if (q_res.size() == 0) unexpected("result_pulse");
            else check("result_true", DATA_W'(result_true), DATA_W'(q_res.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic push(input logic [DATA_W-1:0] v);
        lit_valid = 1'b1;
        lit_data  = v;
        tick();
        lit_valid = 1'b0;
    endtask

    task automatic issue(input logic [7:0] code, input logic [1:0] n);
        op_valid = 1'b1;
        op_code  = code;
        op_nargs = n;
        tick();
        op_valid = 1'b0;
    endtask

    task automatic eval(input logic exp_valid, input logic exp_true);
        if (exp_valid) q_res.push_back(exp_true);
        eval_end = 1'b1;
        tick();
        eval_end = 1'b0;
        tick();
    endtask

    task automatic alu_done(input logic p1, input logic [DATA_W-1:0] d1,
                            input logic p2, input logic [DATA_W-1:0] d2);
        done          = 1'b1;
        put_alu_out1  = p1;
        data_alu_out1 = d1;
        put_alu_out2  = p2;
        data_alu_out2 = d2;
        tick();
        done         = 1'b0;
        put_alu_out1 = 1'b0;
        put_alu_out2 = 1'b0;
    endtask

    typedef struct {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] res;
        logic              exp_true;
    } vec_t;

    vec_t vecs [6];

    initial begin
        rst = 1'b1; lit_valid = 1'b0; lit_data = '0; op_valid = 1'b0; op_code = '0; op_nargs = '0;
        eval_end = 1'b0; put_alu_out1 = 1'b0; data_alu_out1 = '0; put_alu_out2 = 1'b0;
        data_alu_out2 = '0; pop_req = 1'b0; done = 1'b0; error = 1'b0;

        vecs[0] = '{a: 512'h5, b: 512'h5, res: 512'h1, exp_true: 1'b1};
        vecs[1] = '{a: 512'h5, b: 512'h6, res: 512'h0, exp_true: 1'b0};
        vecs[2] = '{a: 512'h0, b: 512'h0, res: 512'h1, exp_true: 1'b1};
        vecs[3] = '{a: 512'h7, b: 512'h3, res: 512'h2, exp_true: 1'b1};
        vecs[4] = '{a: 512'h9, b: 512'h1, res: 512'h0, exp_true: 1'b0};
        vecs[5] = '{a: 512'h1, b: 512'h2, res: {1'b1, 511'b0}, exp_true: 1'b1};

        tick();
        do_reset();
        check("reset_sp", DATA_W'(sp), '0);
        check("reset_in_ready", DATA_W'(in_ready), 1);
        check("reset_opcode", DATA_W'(opcode), '0);
        check("reset_stack_err", DATA_W'(stack_err), '0);
        check("reset_data_in1", data_alu_in1, '0);
        check("reset_flags", DATA_W'({put_alu_in1, put_alu_in2, result_valid, result_true}), '0);
        eval(1'b1, 1'b0);

        // DUP with two results pushed back
        push(512'hAA);
        push(512'hBB);
        q_in1.push_back(512'hBB);
        issue(8'h76, 2'd1);
        check("dup_sp_after_pop", DATA_W'(sp), 1);
        tick();
        check("dup_opcode_held", DATA_W'(opcode), 8'h76);
        alu_done(1'b1, 512'hBB, 1'b1, 512'hBB);
        check("dup_push2_busy", DATA_W'(in_ready), '0);
        tick();
        check("dup_sp_final", DATA_W'(sp), 3);
        check("dup_in_ready", DATA_W'(in_ready), 1);
        check("dup_opcode_cleared", DATA_W'(opcode), '0);
        eval(1'b1, 1'b1);
        check("eval_keeps_sp", DATA_W'(sp), 3);

        // Priority: eval_end wins over op_valid and lit_valid
        q_res.push_back(1'b1);
        eval_end = 1'b1; op_valid = 1'b1; op_nargs = 2'd1; lit_valid = 1'b1; lit_data = 512'h0;
        tick();
        eval_end = 1'b0; op_valid = 1'b0; lit_valid = 1'b0;
        check("priority_sp", DATA_W'(sp), 3);
        check("priority_idle", DATA_W'(in_ready), 1);
        tick();

        // Table-driven two-operand operations followed by a verdict
        for (int i = 0; i < 6; i++) begin
            do_reset();
            push(vecs[i].a);
            push(vecs[i].b);
            q_in1.push_back(vecs[i].b);
            q_in2.push_back(vecs[i].a);
            issue(8'h87, 2'd2);
            check("vec_sp_popped", DATA_W'(sp), '0);
            tick();
            alu_done(1'b1, vecs[i].res, 1'b0, '0);
            check("vec_sp_result", DATA_W'(sp), 1);
            check("vec_in_ready", DATA_W'(in_ready), 1);
            eval(1'b1, vecs[i].exp_true);
        end

        // Not enough operands
        do_reset();
        push(512'h9);
        issue(8'h87, 2'd2);
        check("underflow_err", DATA_W'(stack_err), 1);
        check("underflow_ready", DATA_W'(in_ready), '0);
        check("underflow_sp", DATA_W'(sp), 1);
        push(512'h4);
        check("err_ignores_lit", DATA_W'(sp), 1);
        eval(1'b0, 1'b0);
        do_reset();
        check("err_cleared", DATA_W'({stack_err, in_ready}), 1);

        // nargs==3 is illegal even with a deep stack
        push(512'h1); push(512'h2); push(512'h3);
        issue(8'h10, 2'd3);
        check("nargs3_err", DATA_W'(stack_err), 1);
        check("nargs3_sp", DATA_W'(sp), 3);

        // CHECKMULTISIG pop_req streaming
        do_reset();
        push(512'h11); push(512'h22); push(512'h33); push(512'h44);
        q_in1.push_back(512'h44);
        issue(8'hAE, 2'd1);
        tick();
        q_in1.push_back(512'h33); q_in1.push_back(512'h22); q_in1.push_back(512'h11);
        for (int k = 0; k < 3; k++) begin
            pop_req = 1'b1;
            tick();
            pop_req = 1'b0;
            tick();
        end
        check("multisig_sp_drained", DATA_W'(sp), '0);
        check("multisig_wait", DATA_W'(in_ready), '0);
        alu_done(1'b1, 512'h1, 1'b0, '0);
        check("multisig_sp_result", DATA_W'(sp), 1);
        eval(1'b1, 1'b1);

        // pop_req on an empty stack
        issue(8'hAE, 2'd1);
        q_in1.push_back(512'h1);
        tick();
        pop_req = 1'b1;
        tick();
        pop_req = 1'b0;
        check("pop_empty_err", DATA_W'(stack_err), 1);

        // error beats done in the same cycle
        do_reset();
        push(512'h5); push(512'h6);
        q_in1.push_back(512'h6); q_in2.push_back(512'h5);
        issue(8'h93, 2'd2);
        tick();
        error = 1'b1;
        alu_done(1'b1, 512'h1, 1'b0, '0);
        error = 1'b0;
        check("alu_err_flag", DATA_W'(stack_err), 1);
        check("alu_err_no_push", DATA_W'(sp), '0);
        check("alu_err_ready", DATA_W'(in_ready), '0);
        eval(1'b0, 1'b0);
        do_reset();
        check("alu_err_reset", DATA_W'({sp, stack_err, in_ready}), 1);

        // Fill to DEPTH then overflow
        for (int k = 0; k < DEPTH; k++) push(DATA_W'(k + 1));
        check("full_sp", DATA_W'(sp), DEPTH);
        check("full_ready", DATA_W'(in_ready), 1);
        eval(1'b1, 1'b1);
        push(512'h77);
        check("overflow_err", DATA_W'(stack_err), 1);
        check("overflow_sp", DATA_W'(sp), DEPTH);

        // Reset in the middle of an operation
        do_reset();
        push(512'h1);
        q_in1.push_back(512'h1);
        issue(8'h76, 2'd1);
        tick();
        check("wait_opcode", DATA_W'(opcode), 8'h76);
        do_reset();
        check("midop_reset_opcode", DATA_W'(opcode), '0);
        check("midop_reset_sp", DATA_W'(sp), '0);
        check("midop_reset_ready", DATA_W'(in_ready), 1);
        tick();

        check("queue_in1_drained", DATA_W'(q_in1.size()), '0);
        check("queue_in2_drained", DATA_W'(q_in2.size()), '0);
        check("queue_res_drained", DATA_W'(q_res.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
